pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-PC controller for the pipelined MIPS fetch stage; drives PCNext/PCWrite of the 32-bit PC register.
//  Selects between sequential fetch, branch/jump redirect, exception vector and stall.
//  Holds a redirect pending while instruction memory is busy.
//  Issues IF/ID and ID/EX flush/stall controls.
//  Fetch-timeout watchdog traps to the exception vector.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PCNext driven while Reset=1
//  EXC_VECTOR    32'h8000_0180  exception / timeout target
//  MAX_WAIT      15             consecutive IMemReady=0 cycles before timeout trap (>=1)
// PORTS
//  Clk            in   1   clock; all state updates on posedge
//  Reset          in   1   synchronous, active-high
//  PCResult       in   32  current PC register value
//  BranchTaken    in   1   branch resolved taken this cycle
//  BranchTarget   in   32  branch target address
//  Jump           in   1   jump decoded this cycle
//  JumpTarget     in   32  jump target address
//  Exception      in   1   synchronous exception request
//  LoadUseHazard  in   1   load-use hazard detected in ID
//  IMemReady      in   1   instruction fetch at PCResult completes this cycle
//  PCNext         out  32  next PC value (combinational)
//  PCWrite        out  1   PC register load enable (combinational)
//  IFIDWrite      out  1   IF/ID pipeline register enable
//  IFIDFlush      out  1   insert bubble into IF/ID
//  IDEXFlush      out  1   insert bubble into ID/EX
//  EPC            out  32  registered PC of last trapped fetch
//  FetchTimeout   out  1   registered 1-cycle pulse after a watchdog trap
// BEHAVIOUR
//  State: RUN, REDIRECT. Registers: state, pend_target[31:0], wait_cnt, EPC, FetchTimeout.
//  Reset=1:
//   - Outputs: PCNext=RESET_VECTOR, PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1.
//   - Next cycle: state=RUN, pend_target=0, wait_cnt=0, EPC=0, FetchTimeout=0.
//  Defaults:
//   - PCNext=PCResult+4, mod 2^32 (32'hFFFF_FFFC -> 0).
//   - PCWrite=0, IFIDWrite=1, flushes=0.
//   - PCNext[1:0] is always 2'b00; target bits [1:0] are ignored.
//  Priority each cycle: trap > redirect > load-use > mem-wait > sequential.
//  Trap (Exception=1, or wait_cnt==MAX_WAIT-1 with IMemReady=0):
//   - PCNext=EXC_VECTOR, PCWrite=1, IFIDFlush=1, IDEXFlush=1.
//   - EPC<=PCResult, wait_cnt<=0, state<=RUN, pend discarded.
//   - FetchTimeout<=1 next cycle only if the watchdog caused the trap.
//   - Trap ignores IMemReady (the fetch is aborted).
//  RUN, BranchTaken|Jump (BranchTaken wins if both):
//   - IMemReady=1: PCNext=target, PCWrite=1, IFIDFlush=1; stay in RUN.
//   - IMemReady=0: pend_target<=target, IFIDFlush=1, state<=REDIRECT.
//  RUN, LoadUseHazard=1 (no redirect): PCWrite=0, IFIDWrite=0, IDEXFlush=1. LoadUseHazard is ignored when a redirect is present.
//  RUN, IMemReady=0: PCWrite=0, IFIDWrite=0.
//  RUN, IMemReady=1: PCWrite=1, PCNext=PCResult+4.
//  REDIRECT:
//   - PCNext=pend_target, IFIDFlush=1 every cycle.
//   - BranchTaken, Jump and LoadUseHazard are ignored (wrong path).
//   - PCWrite=IMemReady; on IMemReady=1, state<=RUN.
//  wait_cnt:
//   - +1 per cycle with IMemReady=0 (either state).
//   - Cleared on IMemReady=1, trap, or Reset; saturates at MAX_WAIT-1.
//  Reset mid-REDIRECT drops pend_target; no partial redirect is ever applied.
// TESTING
//  Reset, then IMemReady=1 for 3 cycles, PCResult tracks -> PCNext=0x4, 0x8, 0xC, with PCWrite=1.
//  BranchTaken=1, BranchTarget=0x100, IMemReady=1 -> same cycle PCNext=0x100, PCWrite=1, IFIDFlush=1.
//  Jump, JumpTarget=0x200, IMemReady=0 for 2 cycles then 1:
//   - 2 cycles PCWrite=0, IFIDFlush=1, state REDIRECT.
//   - 3rd cycle PCNext=0x200, PCWrite=1; branch pulses during the wait are ignored.
//  LoadUseHazard=1 at PC=0x40 -> PCWrite=0, IFIDWrite=0, IDEXFlush=1. With BranchTaken also set -> redirect wins.
//  IMemReady=0 for 15 cycles at PC=0x80 (MAX_WAIT=15):
//   - 15th cycle PCNext=0x8000_0180, PCWrite=1.
//   - Then EPC=0x80 and FetchTimeout pulses once.
//  Exception while in REDIRECT -> PCNext=EXC_VECTOR, both flushes asserted, pend dropped, EPC=PCResult.
//  PC=0xFFFF_FFFC sequential -> PCNext=0x0. Reset asserted in REDIRECT -> next cycle state RUN, EPC=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller for the pipelined MIPS fetch stage: sequential fetch, redirects,
// exception/timeout traps, load-use stalls and pipeline flush/stall controls.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          MAX_WAIT     = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Exception,
  input  logic        LoadUseHazard,
  input  logic        IMemReady,
  output logic [31:0] PCNext,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic [31:0] EPC,
  output logic        FetchTimeout
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t         state_reg, state_next;
  logic [31:0]    pend_target_reg, pend_target_next;
  logic [CW-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0]    epc_reg;
  logic           fetch_timeout_reg;

  logic [31:0]    pc_plus4;
  logic [31:0]    redirect_target;
  logic [31:0]    pc_next;
  logic           redirect_req;
  logic           watchdog_trap;
  logic           trap;

  assign pc_plus4        = PCResult + 32'd4;
  assign redirect_req    = BranchTaken | Jump;
  assign redirect_target = BranchTaken ? BranchTarget : JumpTarget;
  assign watchdog_trap   = !IMemReady && (wait_cnt_reg == WAIT_LAST);
  assign trap            = Exception | watchdog_trap;

  always_comb begin
    pc_next          = pc_plus4;
    PCWrite          = 1'b0;
    IFIDWrite        = 1'b1;
    IFIDFlush        = 1'b0;
    IDEXFlush        = 1'b0;
    state_next       = state_reg;
    pend_target_next = pend_target_reg;

    if (trap || IMemReady) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != WAIT_LAST) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end else begin
      wait_cnt_next = wait_cnt_reg;
    end

    if (Reset) begin
      pc_next   = RESET_VECTOR;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (trap) begin
      // The in-flight fetch is aborted, so IMemReady does not gate the PC load.
      pc_next          = EXC_VECTOR;
      PCWrite          = 1'b1;
      IFIDFlush        = 1'b1;
      IDEXFlush        = 1'b1;
      state_next       = RUN;
      pend_target_next = '0;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (redirect_req) begin
            IFIDFlush = 1'b1;
            if (IMemReady) begin
              pc_next = redirect_target;
              PCWrite = 1'b1;
            end else begin
              pend_target_next = redirect_target;
              state_next       = REDIRECT;
            end
          end else if (LoadUseHazard) begin
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end else if (!IMemReady) begin
            IFIDWrite = 1'b0;
          end else begin
            PCWrite = 1'b1;
          end
        end
        REDIRECT: begin
          // Anything decoded here is on the wrong path; only the pending target matters.
          pc_next   = pend_target_reg;
          IFIDFlush = 1'b1;
          PCWrite   = IMemReady;
          if (IMemReady) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign PCNext       = {pc_next[31:2], 2'b00};
  assign EPC          = epc_reg;
  assign FetchTimeout = fetch_timeout_reg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg         <= RUN;
      pend_target_reg   <= '0;
      wait_cnt_reg      <= '0;
      epc_reg           <= '0;
      fetch_timeout_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pend_target_reg   <= pend_target_next;
      wait_cnt_reg      <= wait_cnt_next;
      fetch_timeout_reg <= watchdog_trap;
      if (trap) epc_reg <= PCResult;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: each task drives one scenario and checks
// the combinational next-PC controls plus the registered EPC/FetchTimeout.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic [31:0] PCResult;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Exception;
  logic        LoadUseHazard;
  logic        IMemReady;
  logic [31:0] PCNext;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic [31:0] EPC;
  logic        FetchTimeout;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] EXC = 32'h8000_0180;

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (EXC),
    .MAX_WAIT    (15)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCResult     (PCResult),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Exception    (Exception),
    .LoadUseHazard(LoadUseHazard),
    .IMemReady    (IMemReady),
    .PCNext       (PCNext),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IFIDFlush    (IFIDFlush),
    .IDEXFlush    (IDEXFlush),
    .EPC          (EPC),
    .FetchTimeout (FetchTimeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change 1ns after the edge; outputs are sampled 1ns later, well before the next edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    Reset = 1'b0; PCResult = pc; BranchTaken = 1'b0; BranchTarget = '0;
    Jump = 1'b0; JumpTarget = '0; Exception = 1'b0; LoadUseHazard = 1'b0; IMemReady = 1'b1;
  endtask

  task automatic test_reset();
    idle(32'h0000_1234);
    Reset = 1'b1;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs got PCNext=%h W=%b IFW=%b IFF=%b IDF=%b expected 00000000 0 0 1 1",
               PCNext, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush);
    end
    tick();
    idle(32'h0);
    #1;
    checks++;
    if ({EPC, FetchTimeout} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_regs got EPC=%h FT=%b expected 00000000 0", EPC, FetchTimeout);
    end
    $display("reset: done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      idle(32'(i * 4));
      #1;
      checks++;
      if ({PCNext, PCWrite, IFIDFlush} !== {exp_pc[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL seq%0d got PCNext=%h W=%b IFF=%b expected %h 1 0", i, PCNext, PCWrite, IFIDFlush, exp_pc[i]);
      end
      $display("seq: PC=%h PCNext=%h", PCResult, PCNext);
      tick();
    end
  endtask

  task automatic test_branch();
    idle(32'hC);
    BranchTaken = 1'b1; BranchTarget = 32'h100;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush, IDEXFlush} !== {32'h100, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL branch got PCNext=%h W=%b IFF=%b IDF=%b expected 00000100 1 1 0", PCNext, PCWrite, IFIDFlush, IDEXFlush);
    end
    // Target low bits are dropped; branch beats a simultaneous jump.
    BranchTarget = 32'h0000_0103; Jump = 1'b1; JumpTarget = 32'h0000_0900;
    #1;
    checks++;
    if (PCNext !== 32'h100) begin
      errors++;
      $display("FAIL branch_vs_jump got PCNext=%h expected 00000100", PCNext);
    end
    $display("branch: PCNext=%h", PCNext);
    tick();
  endtask

  task automatic test_redirect_wait();
    idle(32'h100);
    Jump = 1'b1; JumpTarget = 32'h200; IMemReady = 1'b0;
    #1;
    checks++;
    if ({PCWrite, IFIDFlush} !== 2'b01) begin
      errors++;
      $display("FAIL redir_wait0 got W=%b IFF=%b expected 0 1", PCWrite, IFIDFlush);
    end
    tick();
    Jump = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h300; LoadUseHazard = 1'b1;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush, IDEXFlush} !== {32'h200, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL redir_wait1 got PCNext=%h W=%b IFF=%b IDF=%b expected 00000200 0 1 0", PCNext, PCWrite, IFIDFlush, IDEXFlush);
    end
    tick();
    IMemReady = 1'b1; LoadUseHazard = 1'b0;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush} !== {32'h200, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL redir_apply got PCNext=%h W=%b IFF=%b expected 00000200 1 1", PCNext, PCWrite, IFIDFlush);
    end
    tick();
    idle(32'h200);
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush} !== {32'h204, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL redir_back_run got PCNext=%h W=%b IFF=%b expected 00000204 1 0", PCNext, PCWrite, IFIDFlush);
    end
    $display("redirect: pending jump applied at 00000200");
    tick();
  endtask

  task automatic test_load_use();
    idle(32'h40);
    LoadUseHazard = 1'b1;
    #1;
    checks++;
    if ({PCWrite, IFIDWrite, IFIDFlush, IDEXFlush} !== 4'b0001) begin
      errors++;
      $display("FAIL load_use got W=%b IFW=%b IFF=%b IDF=%b expected 0 0 0 1", PCWrite, IFIDWrite, IFIDFlush, IDEXFlush);
    end
    tick();
    BranchTaken = 1'b1; BranchTarget = 32'h500;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush, IDEXFlush} !== {32'h500, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_use_vs_branch got PCNext=%h W=%b IFF=%b IDF=%b expected 00000500 1 1 0", PCNext, PCWrite, IFIDFlush, IDEXFlush);
    end
    $display("load_use: stall then redirect");
    tick();
  endtask

  task automatic test_watchdog();
    idle(32'h80);
    IMemReady = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1;
      checks++;
      if ({PCWrite, IFIDWrite, IDEXFlush} !== 3'b000) begin
        errors++;
        $display("FAIL wd_wait%0d got W=%b IFW=%b IDF=%b expected 0 0 0", i, PCWrite, IFIDWrite, IDEXFlush);
      end
      tick();
    end
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush, IDEXFlush} !== {EXC, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wd_trap got PCNext=%h W=%b IFF=%b IDF=%b expected %h 1 1 1", PCNext, PCWrite, IFIDFlush, IDEXFlush, EXC);
    end
    tick();
    idle(EXC);
    #1;
    checks++;
    if ({EPC, FetchTimeout} !== {32'h80, 1'b1}) begin
      errors++;
      $display("FAIL wd_epc got EPC=%h FT=%b expected 00000080 1", EPC, FetchTimeout);
    end
    tick();
    checks++;
    if (FetchTimeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_pulse got FT=%b expected 0", FetchTimeout);
    end
    $display("watchdog: trap after 15 idle cycles, EPC=%h", EPC);
  endtask

  task automatic test_exception_redirect();
    idle(32'h300);
    Jump = 1'b1; JumpTarget = 32'h600; IMemReady = 1'b0;
    tick();
    Jump = 1'b0; Exception = 1'b1;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush, IDEXFlush} !== {EXC, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL exc_redir got PCNext=%h W=%b IFF=%b IDF=%b expected %h 1 1 1", PCNext, PCWrite, IFIDFlush, IDEXFlush, EXC);
    end
    tick();
    idle(EXC);
    #1;
    checks++;
    if ({PCNext, IFIDFlush, EPC, FetchTimeout} !== {EXC + 32'd4, 1'b0, 32'h300, 1'b0}) begin
      errors++;
      $display("FAIL exc_after got PCNext=%h IFF=%b EPC=%h FT=%b expected %h 0 00000300 0", PCNext, IFIDFlush, EPC, FetchTimeout, EXC + 32'd4);
    end
    $display("exception: trap out of redirect, EPC=%h", EPC);
    tick();
  endtask

  task automatic test_wrap();
    idle(32'hFFFF_FFFC);
    #1;
    checks++;
    if ({PCNext, PCWrite} !== {32'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap got PCNext=%h W=%b expected 00000000 1", PCNext, PCWrite);
    end
    $display("wrap: PCNext=%h", PCNext);
    tick();
  endtask

  task automatic test_reset_in_redirect();
    idle(32'h10);
    Jump = 1'b1; JumpTarget = 32'h700; IMemReady = 1'b0;
    tick();
    idle(32'h10);
    Reset = 1'b1;
    #1;
    checks++;
    if ({PCNext, PCWrite, IFIDFlush, IDEXFlush} !== {32'h0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rst_redir got PCNext=%h W=%b IFF=%b IDF=%b expected 00000000 0 1 1", PCNext, PCWrite, IFIDFlush, IDEXFlush);
    end
    tick();
    idle(32'h0);
    #1;
    checks++;
    if ({PCNext, IFIDFlush, EPC} !== {32'h4, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_redir_after got PCNext=%h IFF=%b EPC=%h expected 00000004 0 00000000", PCNext, IFIDFlush, EPC);
    end
    $display("reset_in_redirect: pending jump dropped");
    tick();
  endtask

  initial begin
    idle(32'h0);
    Reset = 1'b1;
    tick();
    test_reset();
    test_sequential();
    test_branch();
    test_redirect_wait();
    test_load_use();
    test_watchdog();
    test_exception_redirect();
    test_wrap();
    test_reset_in_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
